// File: rtl/bus_arbiter_2.sv
// Two-port arbiter that shares one memory-bus master port between the CPU data
// path (port 0) and instruction fetch / DMA (port 1) using the rw/request/ready handshake.
module bus_arbiter_2 #(
    parameter int ADDRESS_WIDTH = 32,
    parameter bit ROUND_ROBIN   = 1'b1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,

    input  logic                     i_p0_rw,
    input  logic                     i_p0_request,
    output logic                     o_p0_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_p0_address,
    input  logic [31:0]              i_p0_wdata,
    input  logic [3:0]               i_p0_wmask,
    output logic [31:0]              o_p0_rdata,

    input  logic                     i_p1_rw,
    input  logic                     i_p1_request,
    output logic                     o_p1_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_p1_address,
    input  logic [31:0]              i_p1_wdata,
    input  logic [3:0]               i_p1_wmask,
    output logic [31:0]              o_p1_rdata,

    output logic                     o_bus_rw,
    output logic                     o_bus_request,
    input  logic                     i_bus_ready,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    input  logic [31:0]              i_bus_rdata,
    output logic [31:0]              o_bus_wdata,
    output logic [3:0]               o_bus_wmask,

    output logic                     o_grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t state;
    logic   priority_ptr;
    logic   winner;
    logic   bus_done;

    // With both ports requesting, the pointer decides in round-robin mode;
    // in fixed-priority mode port 0 always wins the tie.
    always_comb begin
        winner = 1'b0;
        if (i_p0_request && i_p1_request) begin
            winner = ROUND_ROBIN ? priority_ptr : 1'b0;
        end else if (i_p1_request) begin
            winner = 1'b1;
        end
    end

    // Acknowledge only counts while a bus cycle is actually outstanding.
    assign bus_done = (state == BUSY) && o_bus_request && i_bus_ready;

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state         <= IDLE;
            priority_ptr  <= 1'b0;
            o_grant       <= 1'b0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_bus_wmask   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_p0_request || i_p1_request) begin
                        o_grant       <= winner;
                        o_bus_request <= 1'b1;
                        o_bus_rw      <= winner ? i_p1_rw      : i_p0_rw;
                        o_bus_address <= winner ? i_p1_address : i_p0_address;
                        o_bus_wdata   <= winner ? i_p1_wdata   : i_p0_wdata;
                        o_bus_wmask   <= winner ? i_p1_wmask   : i_p0_wmask;
                        // The port just served loses the next tie.
                        if (ROUND_ROBIN) begin
                            priority_ptr <= ~winner;
                        end
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus_done) begin
                        o_bus_request <= 1'b0;
                        state         <= RELEASE;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    o_bus_request <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign o_p0_ready = bus_done && (o_grant == 1'b0);
    assign o_p1_ready = bus_done && (o_grant == 1'b1);
    assign o_p0_rdata = i_bus_rdata;
    assign o_p1_rdata = i_bus_rdata;

endmodule

// File: tb/tb_bus_arbiter_2.sv
// Directed bench for bus_arbiter_2: a round-robin instance and a fixed-priority
// instance share the requester inputs, each with its own one-cycle-ack bus model.
module tb_bus_arbiter_2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_rw, p1_rw, p0_req, p1_req;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [3:0]  p0_wmask, p1_wmask;
    logic [31:0] bus_rdata;
    logic        bus_stall;

    logic        rr_p0_ready, rr_p1_ready, rr_bus_rw, rr_bus_req, rr_bus_ready, rr_grant;
    logic [31:0] rr_p0_rdata, rr_p1_rdata, rr_bus_addr, rr_bus_wdata;
    logic [3:0]  rr_bus_wmask;
    logic        fp_p0_ready, fp_p1_ready, fp_bus_rw, fp_bus_req, fp_bus_ready, fp_grant;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_bus_addr, fp_bus_wdata;
    logic [3:0]  fp_bus_wmask;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter_2 #(.ADDRESS_WIDTH(32), .ROUND_ROBIN(1'b1)) dut (
        .i_clock(clk), .i_reset(rst_n),
        .i_p0_rw(p0_rw), .i_p0_request(p0_req), .o_p0_ready(rr_p0_ready),
        .i_p0_address(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_wmask(p0_wmask), .o_p0_rdata(rr_p0_rdata),
        .i_p1_rw(p1_rw), .i_p1_request(p1_req), .o_p1_ready(rr_p1_ready),
        .i_p1_address(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_wmask(p1_wmask), .o_p1_rdata(rr_p1_rdata),
        .o_bus_rw(rr_bus_rw), .o_bus_request(rr_bus_req), .i_bus_ready(rr_bus_ready),
        .o_bus_address(rr_bus_addr), .i_bus_rdata(bus_rdata), .o_bus_wdata(rr_bus_wdata),
        .o_bus_wmask(rr_bus_wmask), .o_grant(rr_grant)
    );

    bus_arbiter_2 #(.ADDRESS_WIDTH(32), .ROUND_ROBIN(1'b0)) dut_fp (
        .i_clock(clk), .i_reset(rst_n),
        .i_p0_rw(p0_rw), .i_p0_request(p0_req), .o_p0_ready(fp_p0_ready),
        .i_p0_address(p0_addr), .i_p0_wdata(p0_wdata), .i_p0_wmask(p0_wmask), .o_p0_rdata(fp_p0_rdata),
        .i_p1_rw(p1_rw), .i_p1_request(p1_req), .o_p1_ready(fp_p1_ready),
        .i_p1_address(p1_addr), .i_p1_wdata(p1_wdata), .i_p1_wmask(p1_wmask), .o_p1_rdata(fp_p1_rdata),
        .o_bus_rw(fp_bus_rw), .o_bus_request(fp_bus_req), .i_bus_ready(fp_bus_ready),
        .o_bus_address(fp_bus_addr), .i_bus_rdata(bus_rdata), .o_bus_wdata(fp_bus_wdata),
        .o_bus_wmask(fp_bus_wmask), .o_grant(fp_grant)
    );

    // Bus models acknowledge one cycle after a request is seen, unless stalled.
    always @(posedge clk) begin
        if (!rst_n) begin
            rr_bus_ready <= 1'b0;
            fp_bus_ready <= 1'b0;
        end else begin
            rr_bus_ready <= rr_bus_req && !rr_bus_ready && !bus_stall;
            fp_bus_ready <= fp_bus_req && !fp_bus_ready && !bus_stall;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rr_bus_req, rr_bus_rw, rr_grant, rr_p0_ready, rr_p1_ready} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_rr_ctrl: got %b expected 00000",
                     {rr_bus_req, rr_bus_rw, rr_grant, rr_p0_ready, rr_p1_ready});
        end
        checks++;
        if ({rr_bus_addr, rr_bus_wdata, rr_bus_wmask} !== 68'h0) begin
            errors++;
            $display("[TB] FAIL reset_rr_data: got %h expected 0", {rr_bus_addr, rr_bus_wdata, rr_bus_wmask});
        end
        checks++;
        if ({fp_bus_req, fp_grant, fp_bus_addr} !== 34'h0) begin
            errors++;
            $display("[TB] FAIL reset_fp: got %h expected 0", {fp_bus_req, fp_grant, fp_bus_addr});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        p0_rw = 1'b1; p0_addr = 32'hcafe_0001; p0_wdata = 32'hb00b_1111; p0_wmask = 4'b1111;
        p0_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({rr_bus_req, rr_grant, rr_bus_rw} !== 3'b101) begin
            errors++;
            $display("[TB] FAIL write_req: got req/grant/rw %b expected 101", {rr_bus_req, rr_grant, rr_bus_rw});
        end
        checks++;
        if ({rr_bus_addr, rr_bus_wdata, rr_bus_wmask} !== {32'hcafe_0001, 32'hb00b_1111, 4'hf}) begin
            errors++;
            $display("[TB] FAIL write_fields: got %h expected cafe0001b00b1111f",
                     {rr_bus_addr, rr_bus_wdata, rr_bus_wmask});
        end
        checks++;
        if (rr_p0_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_early_ready: got %b expected 0", rr_p0_ready);
        end
        @(negedge clk);
        checks++;
        if ({rr_p0_ready, rr_p1_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL write_ready: got p0/p1 %b expected 10", {rr_p0_ready, rr_p1_ready});
        end
        p0_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({rr_bus_req, rr_p0_ready, rr_p1_ready} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL write_release: got req/p0/p1 %b expected 000", {rr_bus_req, rr_p0_ready, rr_p1_ready});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_return();
        bus_rdata = 32'hdead_beef;
        p1_rw = 1'b0; p1_addr = 32'hcafe_0005; p1_wdata = 32'h0; p1_wmask = 4'h0;
        p1_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({rr_bus_req, rr_grant, rr_bus_rw, rr_bus_addr} !== {3'b110, 32'hcafe_0005}) begin
            errors++;
            $display("[TB] FAIL read_req: got %h expected 6cafe0005", {rr_bus_req, rr_grant, rr_bus_rw, rr_bus_addr});
        end
        @(negedge clk);
        checks++;
        if ({rr_p1_ready, rr_p0_ready, rr_p1_rdata} !== {2'b10, 32'hdead_beef}) begin
            errors++;
            $display("[TB] FAIL read_data: got %h expected 2deadbeef", {rr_p1_ready, rr_p0_ready, rr_p1_rdata});
        end
        p1_req = 1'b0;
        @(negedge clk);
        checks++;
        if (rr_p1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL read_pulse: got %b expected 0", rr_p1_ready);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention_rr();
        int n = 0, c0 = 0, c1 = 0;
        logic prev_ready = 1'b0;
        logic who;
        p0_rw = 1'b0; p0_addr = 32'h0000_0100;
        p1_rw = 1'b0; p1_addr = 32'h0000_0200;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int cyc = 0; cyc < 80 && n < 8; cyc++) begin
            @(negedge clk);
            if (rr_p0_ready && rr_p1_ready) begin
                checks++; errors++;
                $display("[TB] FAIL rr_both_ready: got 11 expected at most one");
            end
            if (rr_p0_ready || rr_p1_ready) begin
                who = rr_p1_ready;
                checks++;
                if (who !== n[0]) begin
                    errors++;
                    $display("[TB] FAIL rr_order: transaction %0d got port %0d expected %0d", n, who, n[0]);
                end
                checks++;
                if (rr_bus_addr !== (who ? 32'h0000_0200 : 32'h0000_0100)) begin
                    errors++;
                    $display("[TB] FAIL rr_addr: got %h expected %h", rr_bus_addr,
                             who ? 32'h0000_0200 : 32'h0000_0100);
                end
                checks++;
                if (prev_ready !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rr_pulse_width: got ready on consecutive cycles expected single pulse");
                end
                if (who) c1++; else c0++;
                n++;
                if (c0 == 4) p0_req = 1'b0;
                if (c1 == 4) p1_req = 1'b0;
            end
            prev_ready = rr_p0_ready || rr_p1_ready;
        end
        checks++;
        if (n != 8 || c0 != 4 || c1 != 4) begin
            errors++;
            $display("[TB] FAIL rr_counts: got total %0d p0 %0d p1 %0d expected 8/4/4", n, c0, c1);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        logic [2:0] seq = 3'b000;
        int n = 0, c0 = 0;
        p0_addr = 32'h0000_0300; p1_addr = 32'h0000_0400;
        p0_req = 1'b1; p1_req = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 3; cyc++) begin
            @(negedge clk);
            if (fp_p0_ready || fp_p1_ready) begin
                seq[n] = fp_p1_ready;
                n++;
                if (fp_p0_ready) c0++;
                if (c0 == 2) p0_req = 1'b0;
                if (fp_p1_ready) p1_req = 1'b0;
            end
        end
        checks++;
        if (n != 3 || seq !== 3'b100) begin
            errors++;
            $display("[TB] FAIL fp_order: got %0d grants order(lsb first) %b expected 3 grants 100", n, seq);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_stability();
        logic held_ok = 1'b1;
        bus_stall = 1'b1;
        p0_rw = 1'b1; p0_addr = 32'h1234_0000; p0_wdata = 32'h0000_aaaa; p0_wmask = 4'b0011;
        p0_req = 1'b1;
        @(negedge clk);
        p0_addr = 32'h5555_5555; p0_wdata = 32'hffff_ffff; p0_wmask = 4'b1100; p0_rw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rr_bus_addr !== 32'h1234_0000 || rr_bus_req !== 1'b1 || rr_p0_ready !== 1'b0) held_ok = 1'b0;
        end
        checks++;
        if (held_ok !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stable_hold: got addr %h req %b expected 12340000 held with req 1", rr_bus_addr, rr_bus_req);
        end
        bus_stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({rr_p0_ready, rr_bus_addr, rr_bus_wdata, rr_bus_wmask, rr_bus_rw} !== {1'b1, 32'h1234_0000, 32'h0000_aaaa, 4'b0011, 1'b1}) begin
            errors++;
            $display("[TB] FAIL stable_at_ready: got %h expected %h",
                     {rr_p0_ready, rr_bus_addr, rr_bus_wdata, rr_bus_wmask, rr_bus_rw},
                     {1'b1, 32'h1234_0000, 32'h0000_aaaa, 4'b0011, 1'b1});
        end
        p0_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        bus_stall = 1'b1;
        p1_rw = 1'b1; p1_addr = 32'h0000_0abc; p1_wdata = 32'h1357_9bdf; p1_wmask = 4'b1010;
        p1_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rr_bus_req, rr_grant} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL midop_busy: got req/grant %b expected 11", {rr_bus_req, rr_grant});
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({rr_bus_req, rr_bus_rw, rr_grant, rr_p0_ready, rr_p1_ready, rr_bus_addr, rr_bus_wdata, rr_bus_wmask} !== 73'h0) begin
            errors++;
            $display("[TB] FAIL midop_reset: got %h expected 0",
                     {rr_bus_req, rr_bus_rw, rr_grant, rr_p0_ready, rr_p1_ready, rr_bus_addr, rr_bus_wdata, rr_bus_wmask});
        end
        p1_req = 1'b0;
        rst_n = 1'b1;
        bus_stall = 1'b0;
        @(negedge clk);
        p1_rw = 1'b0; p1_addr = 32'h0000_0077;
        p1_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({rr_bus_req, rr_grant, rr_bus_rw, rr_bus_addr} !== {3'b110, 32'h0000_0077}) begin
            errors++;
            $display("[TB] FAIL midop_regrant: got %h expected 600000077", {rr_bus_req, rr_grant, rr_bus_rw, rr_bus_addr});
        end
        @(negedge clk);
        checks++;
        if (rr_p1_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midop_ready: got %b expected 1", rr_p1_ready);
        end
        p1_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; bus_stall = 1'b0; bus_rdata = 32'h0;
        p0_rw = 1'b0; p0_req = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_wmask = 4'h0;
        p1_rw = 1'b0; p1_req = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_wmask = 4'h0;
        test_reset();
        test_single_write();
        test_read_return();
        test_contention_rr();
        test_fixed_priority();
        test_stability();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
